// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants and the pipeline record used by the register-file read arbiter.
// The record carries one request from acceptance to response.
package regfile_read_arbiter_pkg;

   localparam logic       OWNER_RS     = 1'b0;
   localparam logic       OWNER_LSB    = 1'b1;
   localparam logic [4:0] REG_ZERO     = 5'd0;
   localparam int         RF_TAG_WIDTH = 2;

   typedef logic [RF_TAG_WIDTH-1:0] rf_tag_t;

   // Operand index 0 is rs1, index 1 is rs2.
   typedef struct packed {
      logic             valid;
      logic             owner;
      rf_tag_t          tag;
      logic [1:0]       en;
      logic [1:0][4:0]  rd;
      logic [1:0]       fwd_hit;
      logic [1:0][31:0] fwd_data;
   } pipe_rec_t;

   // True when a commit of rob_rd overwrites an operand this record still needs.
   function automatic logic rob_matches(input logic rob_valid, input logic [4:0] rob_rd,
                                        input logic en, input logic [4:0] rd);
      return rob_valid && (rob_rd != REG_ZERO) && en && (rd == rob_rd);
   endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Bundle of requester, register-file, ROB and response signals around the read arbiter.
// master = surrounding core/environment, slave = the arbiter.
interface regfile_read_arbiter_if #(
   parameter int TAG_WIDTH = 2
);
   logic                 rs_req;
   logic                 rs_rs1_en;
   logic                 rs_rs2_en;
   logic [4:0]           rs_rs1;
   logic [4:0]           rs_rs2;
   logic [TAG_WIDTH-1:0] rs_tag;
   logic                 rs_grant;

   logic                 lsb_req;
   logic                 lsb_rs1_en;
   logic                 lsb_rs2_en;
   logic [4:0]           lsb_rs1;
   logic [4:0]           lsb_rs2;
   logic [TAG_WIDTH-1:0] lsb_tag;
   logic                 lsb_grant;

   logic                 to_rf_rs1_flag;
   logic                 to_rf_rs2_flag;
   logic [4:0]           to_rf_rs1;
   logic [4:0]           to_rf_rs2;
   logic [TAG_WIDTH-1:0] to_rf_index;

   logic                 from_rf_rs1_flag;
   logic                 from_rf_rs2_flag;
   logic [TAG_WIDTH-1:0] from_rf_index;
   logic [31:0]          from_rf_rs1;
   logic [31:0]          from_rf_rs2;

   logic                 from_rob;
   logic [4:0]           from_rob_rd;
   logic [31:0]          from_rob_wdata;

   logic                 rsp_valid;
   logic                 rsp_owner;
   logic [TAG_WIDTH-1:0] rsp_tag;
   logic                 rsp_rs1_valid;
   logic                 rsp_rs2_valid;
   logic [31:0]          rsp_rs1;
   logic [31:0]          rsp_rs2;

   modport master (
      output rs_req, rs_rs1_en, rs_rs2_en, rs_rs1, rs_rs2, rs_tag,
      input  rs_grant,
      output lsb_req, lsb_rs1_en, lsb_rs2_en, lsb_rs1, lsb_rs2, lsb_tag,
      input  lsb_grant,
      input  to_rf_rs1_flag, to_rf_rs2_flag, to_rf_rs1, to_rf_rs2, to_rf_index,
      output from_rf_rs1_flag, from_rf_rs2_flag, from_rf_index, from_rf_rs1, from_rf_rs2,
      output from_rob, from_rob_rd, from_rob_wdata,
      input  rsp_valid, rsp_owner, rsp_tag, rsp_rs1_valid, rsp_rs2_valid, rsp_rs1, rsp_rs2
   );

   modport slave (
      input  rs_req, rs_rs1_en, rs_rs2_en, rs_rs1, rs_rs2, rs_tag,
      output rs_grant,
      input  lsb_req, lsb_rs1_en, lsb_rs2_en, lsb_rs1, lsb_rs2, lsb_tag,
      output lsb_grant,
      output to_rf_rs1_flag, to_rf_rs2_flag, to_rf_rs1, to_rf_rs2, to_rf_index,
      input  from_rf_rs1_flag, from_rf_rs2_flag, from_rf_index, from_rf_rs1, from_rf_rs2,
      input  from_rob, from_rob_rd, from_rob_wdata,
      output rsp_valid, rsp_owner, rsp_tag, rsp_rs1_valid, rsp_rs2_valid, rsp_rs1, rsp_rs2
   );

endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter between RS and LSB; on a conflict the requester
// that did not win last time is granted. Grants are combinational.
module rr_arbiter2
   import regfile_read_arbiter_pkg::*;
(
   input  logic clk_in,
   input  logic rst_in,
   input  logic rdy_in,
   input  logic req_rs,
   input  logic req_lsb,
   output logic grant_rs,
   output logic grant_lsb
);

   logic last_owner_reg;

   always_comb begin
      grant_rs  = 1'b0;
      grant_lsb = 1'b0;
      if (rdy_in) begin
         if (req_rs && req_lsb) begin
            grant_rs  = (last_owner_reg == OWNER_LSB);
            grant_lsb = (last_owner_reg == OWNER_RS);
         end else begin
            grant_rs  = req_rs;
            grant_lsb = req_lsb;
         end
      end
   end

   // Reset to LSB so the RS wins the first conflict.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_owner_reg <= OWNER_LSB;
      end else if (grant_rs) begin
         last_owner_reg <= OWNER_RS;
      end else if (grant_lsb) begin
         last_owner_reg <= OWNER_LSB;
      end
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register file read port between RS and LSB: S1 drives the read,
// S2 waits for the data and catches ROB commits, the response register picks the operand.
module regfile_read_arbiter
   import regfile_read_arbiter_pkg::*;
#(
   parameter int TAG_WIDTH = RF_TAG_WIDTH
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   regfile_read_arbiter_if.slave bus
);

   logic             grant_rs;
   logic             grant_lsb;
   pipe_rec_t        req_rec;
   pipe_rec_t        s1_reg;
   pipe_rec_t        s2_reg;
   pipe_rec_t        s2_next;

   logic [1:0]       to_rf_flag;
   logic [1:0]       fwd_e1;
   logic [1:0][31:0] fwd_data_e1;
   logic [1:0]       fwd_e2;
   logic [1:0]       rf_expect;
   logic [1:0]       rf_flag;
   logic [1:0][31:0] rf_data;
   logic [1:0]       opnd_valid_next;
   logic [1:0][31:0] opnd_data_next;

   logic                 rsp_valid_reg;
   logic                 rsp_owner_reg;
   logic [TAG_WIDTH-1:0] rsp_tag_reg;
   logic [1:0]           rsp_opnd_valid_reg;
   logic [1:0][31:0]     rsp_opnd_data_reg;

   rr_arbiter2 u_arb (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .req_rs    (bus.rs_req),
      .req_lsb   (bus.lsb_req),
      .grant_rs  (grant_rs),
      .grant_lsb (grant_lsb)
   );

   assign bus.rs_grant  = grant_rs;
   assign bus.lsb_grant = grant_lsb;

   always_comb begin
      req_rec = '0;
      if (grant_lsb) begin
         req_rec.valid = 1'b1;
         req_rec.owner = OWNER_LSB;
         req_rec.tag   = bus.lsb_tag;
         req_rec.en    = {bus.lsb_rs2_en, bus.lsb_rs1_en};
         req_rec.rd    = {bus.lsb_rs2, bus.lsb_rs1};
      end else if (grant_rs) begin
         req_rec.valid = 1'b1;
         req_rec.owner = OWNER_RS;
         req_rec.tag   = bus.rs_tag;
         req_rec.en    = {bus.rs_rs2_en, bus.rs_rs1_en};
         req_rec.rd    = {bus.rs_rs2, bus.rs_rs1};
      end
   end

   assign rf_data = {bus.from_rf_rs2, bus.from_rf_rs1};
   assign rf_flag = {bus.from_rf_rs2_flag, bus.from_rf_rs1_flag};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         // x0 is never read from the file; its value is known.
         assign to_rf_flag[gi] = s1_reg.valid && s1_reg.en[gi] && (s1_reg.rd[gi] != REG_ZERO);

         assign fwd_e1[gi] = rob_matches(bus.from_rob, bus.from_rob_rd,
                                         s1_reg.en[gi], s1_reg.rd[gi]);
         assign fwd_data_e1[gi] = fwd_e1[gi] ? bus.from_rob_wdata : 32'h0;

         assign fwd_e2[gi] = rob_matches(bus.from_rob, bus.from_rob_rd,
                                         s2_reg.en[gi], s2_reg.rd[gi]);
         assign rf_expect[gi] = s2_reg.valid && s2_reg.en[gi] && (s2_reg.rd[gi] != REG_ZERO);

         // Newest value wins: commit at this edge, then the earlier forward, then the file.
         assign opnd_valid_next[gi] = s2_reg.valid && s2_reg.en[gi];
         assign opnd_data_next[gi]  = !opnd_valid_next[gi]        ? 32'h0 :
                                      fwd_e2[gi]                  ? bus.from_rob_wdata :
                                      s2_reg.fwd_hit[gi]          ? s2_reg.fwd_data[gi] :
                                      (s2_reg.rd[gi] == REG_ZERO) ? 32'h0 :
                                                                    rf_data[gi];
      end
   endgenerate

   always_comb begin
      s2_next          = s1_reg;
      s2_next.fwd_hit  = fwd_e1;
      s2_next.fwd_data = fwd_data_e1;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_reg             <= '0;
         s2_reg             <= '0;
         rsp_valid_reg      <= 1'b0;
         rsp_owner_reg      <= 1'b0;
         rsp_tag_reg        <= '0;
         rsp_opnd_valid_reg <= '0;
         rsp_opnd_data_reg  <= '0;
      end else if (rdy_in) begin
         s1_reg             <= req_rec;
         s2_reg             <= s2_next;
         rsp_valid_reg      <= s2_reg.valid;
         rsp_owner_reg      <= s2_reg.valid ? s2_reg.owner : 1'b0;
         rsp_tag_reg        <= s2_reg.valid ? s2_reg.tag : '0;
         rsp_opnd_valid_reg <= opnd_valid_next;
         rsp_opnd_data_reg  <= opnd_data_next;
      end
   end

   assign bus.to_rf_rs1_flag = to_rf_flag[0];
   assign bus.to_rf_rs2_flag = to_rf_flag[1];
   assign bus.to_rf_rs1      = s1_reg.rd[0];
   assign bus.to_rf_rs2      = s1_reg.rd[1];
   assign bus.to_rf_index    = s1_reg.tag;

   assign bus.rsp_valid     = rsp_valid_reg;
   assign bus.rsp_owner     = rsp_owner_reg;
   assign bus.rsp_tag       = rsp_tag_reg;
   assign bus.rsp_rs1_valid = rsp_opnd_valid_reg[0];
   assign bus.rsp_rs2_valid = rsp_opnd_valid_reg[1];
   assign bus.rsp_rs1       = rsp_opnd_data_reg[0];
   assign bus.rsp_rs2       = rsp_opnd_data_reg[1];

   // The register file has no back-pressure: a read it was asked for must come back tagged.
   rf_resp_check : assert property (@(posedge clk_in) disable iff (rst_in)
      (rdy_in && (rf_expect != 2'b00)) |->
         (((rf_flag & rf_expect) == rf_expect) && (bus.from_rf_index == s2_reg.tag)));

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus random traffic, checked against
// an architectural register-file model (operand = register value after the response edge).
module tb_regfile_read_arbiter;
   import regfile_read_arbiter_pkg::*;

   localparam int TW = 2;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;

   regfile_read_arbiter_if #(.TAG_WIDTH(TW)) bus ();

   regfile_read_arbiter #(.TAG_WIDTH(TW)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic          owner;
      logic [TW-1:0] tag;
      logic [1:0]    en;
      logic [4:0]    rd1;
      logic [4:0]    rd0;
      logic [31:0]   due;
   } exp_t;

   logic [31:0] regs [32];
   exp_t        pend [$];
   logic        exp_last;
   logic        exp_rsp_valid;
   int          active_edges;
   int          checks;
   int          failures;
   logic        last_g_rs;
   logic        last_g_lsb;
   int          rsp_count;
   logic        last_rsp_owner;
   logic        last_rsp_v1;
   logic        last_rsp_v2;
   logic [31:0] last_rsp_d1;
   logic [31:0] last_rsp_d2;
   logic        owner_log [$];
   int          edge_log [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: predict grants, advance the models at the edge, check the response.
   task automatic step();
      logic          pre_rst, pre_rdy, g_rs, g_lsb, rob_v;
      logic [1:0]    sf;
      logic [4:0]    sa0, sa1, rob_rd;
      logic [TW-1:0] sidx;
      logic [31:0]   rob_d, d0, d1;
      exp_t          req_e, e;
      #1;
      pre_rst = rst_in;
      pre_rdy = rdy_in;
      g_rs    = 1'b0;
      g_lsb   = 1'b0;
      if (!pre_rst) begin
         g_rs  = pre_rdy && bus.rs_req && (!bus.lsb_req || exp_last == OWNER_LSB);
         g_lsb = pre_rdy && bus.lsb_req && (!bus.rs_req || exp_last == OWNER_RS);
         check("rs_grant", 32'(bus.rs_grant), 32'(g_rs));
         check("lsb_grant", 32'(bus.lsb_grant), 32'(g_lsb));
      end
      req_e = '0;
      if (g_lsb) begin
         req_e.owner = 1'b1; req_e.tag = bus.lsb_tag;
         req_e.en = {bus.lsb_rs2_en, bus.lsb_rs1_en};
         req_e.rd0 = bus.lsb_rs1; req_e.rd1 = bus.lsb_rs2;
      end else if (g_rs) begin
         req_e.owner = 1'b0; req_e.tag = bus.rs_tag;
         req_e.en = {bus.rs_rs2_en, bus.rs_rs1_en};
         req_e.rd0 = bus.rs_rs1; req_e.rd1 = bus.rs_rs2;
      end
      sf     = {bus.to_rf_rs2_flag, bus.to_rf_rs1_flag};
      sa0    = bus.to_rf_rs1;
      sa1    = bus.to_rf_rs2;
      sidx   = bus.to_rf_index;
      rob_v  = bus.from_rob;
      rob_rd = bus.from_rob_rd;
      rob_d  = bus.from_rob_wdata;
      @(posedge clk_in);
      #1;
      last_g_rs  = g_rs;
      last_g_lsb = g_lsb;
      if (pre_rst) begin
         pend.delete();
         exp_last = OWNER_LSB;
         exp_rsp_valid = 1'b0;
         bus.from_rf_rs1_flag = 1'b0;
         bus.from_rf_rs2_flag = 1'b0;
         check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
         check("rst_rsp_owner", 32'(bus.rsp_owner), 32'h0);
         check("rst_rsp_tag", 32'(bus.rsp_tag), 32'h0);
         check("rst_rsp_vbits", 32'({bus.rsp_rs2_valid, bus.rsp_rs1_valid}), 32'h0);
         check("rst_rsp_rs1", bus.rsp_rs1, 32'h0);
         check("rst_rsp_rs2", bus.rsp_rs2, 32'h0);
         check("rst_to_rf_flags", 32'({bus.to_rf_rs2_flag, bus.to_rf_rs1_flag}), 32'h0);
         check("rst_to_rf_index", 32'(bus.to_rf_index), 32'h0);
      end else if (pre_rdy) begin
         active_edges++;
         // Register file: data read at this edge, before this edge's commit.
         bus.from_rf_rs1_flag = sf[0];
         bus.from_rf_rs2_flag = sf[1];
         bus.from_rf_rs1      = sf[0] ? regs[sa0] : $urandom();
         bus.from_rf_rs2      = sf[1] ? regs[sa1] : $urandom();
         bus.from_rf_index    = sidx;
         if (rob_v && rob_rd != 5'd0) regs[rob_rd] = rob_d;
         if (pend.size() > 0 && pend[0].due == 32'(active_edges)) begin
            e  = pend.pop_front();
            d0 = e.en[0] ? regs[e.rd0] : 32'h0;
            d1 = e.en[1] ? regs[e.rd1] : 32'h0;
            check("rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("rsp_owner", 32'(bus.rsp_owner), 32'(e.owner));
            check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            check("rsp_rs1_valid", 32'(bus.rsp_rs1_valid), 32'(e.en[0]));
            check("rsp_rs2_valid", 32'(bus.rsp_rs2_valid), 32'(e.en[1]));
            check("rsp_rs1", bus.rsp_rs1, d0);
            check("rsp_rs2", bus.rsp_rs2, d1);
            $display("rsp %0d owner=%0d tag=%0d rs1(x%0d)=%0d:%h rs2(x%0d)=%0d:%h",
                     rsp_count, bus.rsp_owner, bus.rsp_tag, e.rd0, bus.rsp_rs1_valid,
                     bus.rsp_rs1, e.rd1, bus.rsp_rs2_valid, bus.rsp_rs2);
            last_rsp_owner = bus.rsp_owner;
            last_rsp_v1    = bus.rsp_rs1_valid;
            last_rsp_v2    = bus.rsp_rs2_valid;
            last_rsp_d1    = bus.rsp_rs1;
            last_rsp_d2    = bus.rsp_rs2;
            owner_log.push_back(bus.rsp_owner);
            edge_log.push_back(active_edges);
            rsp_count++;
            exp_rsp_valid = 1'b1;
         end else begin
            check("rsp_idle", 32'(bus.rsp_valid), 32'h0);
            exp_rsp_valid = 1'b0;
         end
         if (g_rs || g_lsb) begin
            req_e.due = 32'(active_edges + 2);
            pend.push_back(req_e);
            exp_last = g_lsb;
         end
      end else begin
         check("rsp_hold", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
      end
   endtask

   task automatic req_rs(input logic e1, input logic e2, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [TW-1:0] t);
      bus.rs_req = 1'b1; bus.rs_rs1_en = e1; bus.rs_rs2_en = e2;
      bus.rs_rs1 = r1; bus.rs_rs2 = r2; bus.rs_tag = t;
   endtask

   task automatic req_lsb(input logic e1, input logic e2, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [TW-1:0] t);
      bus.lsb_req = 1'b1; bus.lsb_rs1_en = e1; bus.lsb_rs2_en = e2;
      bus.lsb_rs1 = r1; bus.lsb_rs2 = r2; bus.lsb_tag = t;
   endtask

   task automatic rob_write(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.from_rob = v; bus.from_rob_rd = rd; bus.from_rob_wdata = d;
   endtask

   task automatic idle();
      bus.rs_req = 1'b0; bus.lsb_req = 1'b0;
      rob_write(1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      int c0;
      checks = 0; failures = 0; active_edges = 0; rsp_count = 0;
      exp_last = OWNER_LSB; exp_rsp_valid = 1'b0;
      last_g_rs = 1'b0; last_g_lsb = 1'b0;
      last_rsp_owner = 1'b0; last_rsp_v1 = 1'b0; last_rsp_v2 = 1'b0;
      last_rsp_d1 = 32'h0; last_rsp_d2 = 32'h0;
      regs[0] = 32'h0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom();
      req_rs(1'b0, 1'b0, 5'd0, 5'd0, '0);
      req_lsb(1'b0, 1'b0, 5'd0, 5'd0, '0);
      idle();
      bus.from_rf_rs1_flag = 1'b0; bus.from_rf_rs2_flag = 1'b0;
      bus.from_rf_rs1 = 32'h0; bus.from_rf_rs2 = 32'h0; bus.from_rf_index = '0;
      rst_in = 1'b1; rdy_in = 1'b1;
      step(); step();
      rst_in = 1'b0;

      // Conflict for three cycles straight after reset: RS, LSB, RS.
      owner_log.delete(); edge_log.delete();
      req_rs(1'b1, 1'b1, 5'd1, 5'd2, 2'd0); req_lsb(1'b1, 1'b1, 5'd3, 5'd4, 2'd1);
      step();
      req_rs(1'b1, 1'b1, 5'd5, 5'd6, 2'd2);
      step();
      req_lsb(1'b1, 1'b0, 5'd7, 5'd0, 2'd3);
      step();
      idle();
      step(); step(); step();
      check("t2_count", 32'(owner_log.size()), 32'd3);
      if (owner_log.size() >= 3) begin
         check("t2_owner0", 32'(owner_log[0]), 32'd0);
         check("t2_owner1", 32'(owner_log[1]), 32'd1);
         check("t2_owner2", 32'(owner_log[2]), 32'd0);
         check("t2_b2b_a", 32'(edge_log[1] - edge_log[0]), 32'd1);
         check("t2_b2b_b", 32'(edge_log[2] - edge_log[1]), 32'd1);
      end

      // RS-only read of x5/x6.
      regs[5] = 32'h11; regs[6] = 32'h22;
      req_rs(1'b1, 1'b1, 5'd5, 5'd6, 2'd1);
      step(); idle();
      check("t1_rf_flag1", 32'(bus.to_rf_rs1_flag), 32'h1);
      check("t1_rf_addr1", 32'(bus.to_rf_rs1), 32'd5);
      check("t1_rf_index", 32'(bus.to_rf_index), 32'd1);
      c0 = rsp_count;
      step();
      check("t1_not_early", 32'(rsp_count - c0), 32'd0);
      step();
      check("t1_owner", 32'(last_rsp_owner), 32'd0);
      check("t1_rs1", last_rsp_d1, 32'h11);
      check("t1_rs2", last_rsp_d2, 32'h22);
      check("t1_valids", 32'({last_rsp_v2, last_rsp_v1}), 32'h3);

      // x0 read with rs2 disabled.
      req_rs(1'b1, 1'b0, 5'd0, 5'd7, 2'd2);
      step(); idle();
      check("t3_rf_flag1", 32'(bus.to_rf_rs1_flag), 32'h0);
      check("t3_rf_flag2", 32'(bus.to_rf_rs2_flag), 32'h0);
      step(); step();
      check("t3_rs1", last_rsp_d1, 32'h0);
      check("t3_valids", 32'({last_rsp_v2, last_rsp_v1}), 32'h1);

      // Forward at E1, then a separate forward at E2.
      regs[9] = 32'h1;
      req_rs(1'b1, 1'b0, 5'd9, 5'd0, 2'd3);
      step(); idle();
      rob_write(1'b1, 5'd9, 32'hABCD);
      step(); idle();
      step();
      check("t4_fwd_e1", last_rsp_d1, 32'hABCD);
      req_lsb(1'b1, 1'b0, 5'd9, 5'd0, 2'd0);
      step(); idle();
      step();
      rob_write(1'b1, 5'd9, 32'hBEEF);
      step(); idle();
      check("t4_fwd_e2", last_rsp_d1, 32'hBEEF);

      // Commits to x0 never forward.
      req_rs(1'b1, 1'b0, 5'd0, 5'd0, 2'd1);
      step(); idle();
      rob_write(1'b1, 5'd0, 32'hFFFF);
      step(); step(); idle();
      check("t5_x0", last_rsp_d1, 32'h0);

      // Three stalled cycles with two reads in flight.
      req_rs(1'b1, 1'b1, 5'd10, 5'd11, 2'd2);
      step(); idle();
      req_lsb(1'b1, 1'b1, 5'd12, 5'd13, 2'd3);
      step();
      req_rs(1'b1, 1'b0, 5'd14, 5'd0, 2'd0);
      rdy_in = 1'b0;
      c0 = rsp_count;
      step(); step(); step();
      check("t6_stalled", 32'(rsp_count - c0), 32'd0);
      idle();
      rdy_in = 1'b1;
      step(); step();
      check("t6_drained", 32'(rsp_count - c0), 32'd2);

      // Reset with two reads in flight drops both.
      req_rs(1'b1, 1'b1, 5'd3, 5'd4, 2'd1);
      step(); idle();
      req_lsb(1'b1, 1'b1, 5'd5, 5'd6, 2'd2);
      step(); idle();
      rst_in = 1'b1;
      c0 = rsp_count;
      step();
      rst_in = 1'b0;
      step(); step(); step(); step();
      check("t7_dropped", 32'(rsp_count - c0), 32'd0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         if (!bus.rs_req && $urandom_range(0, 99) < 55)
            req_rs(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), TW'($urandom()));
         if (!bus.lsb_req && $urandom_range(0, 99) < 55)
            req_lsb(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), TW'($urandom()));
         rdy_in = ($urandom_range(0, 9) != 0);
         if (rdy_in && $urandom_range(0, 1) == 1)
            rob_write(1'b1, 5'($urandom_range(0, 7)), $urandom());
         else
            rob_write(1'b0, 5'd0, 32'h0);
         rst_in = ($urandom_range(0, 499) == 0);
         if (rst_in) begin
            bus.rs_req = 1'b0; bus.lsb_req = 1'b0;
         end
         step();
         if (last_g_rs) bus.rs_req = 1'b0;
         if (last_g_lsb) bus.lsb_req = 1'b0;
      end
      rst_in = 1'b0; rdy_in = 1'b1; idle();
      step(); step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
